loop_program_counter: RTL and testbench

//   Programmable successor to the single-range program counter. Generates memory

---
 rtl/loop_program_counter_if.sv | 30 +++
 rtl/loop_program_counter.sv | 89 ++++++++
 tb/tb_loop_program_counter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/loop_program_counter_if.sv
// loop_program_counter_if: control/config/status bundle between sequencer and program counter
interface loop_program_counter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int STEP_WIDTH = 4
);
    logic                  tick;
    logic                  start;
    logic                  stop;
    logic                  loopMode;
    logic [ADDR_WIDTH-1:0] startAddr;
    logic [ADDR_WIDTH-1:0] endAddr;
    logic [STEP_WIDTH-1:0] step;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] jumpAddr;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  running;
    logic                  wrap;
    logic                  done;
    logic                  cfgErr;

    modport master (
        output tick, start, stop, loopMode, startAddr, endAddr, step, jump, jumpAddr,
        input  memAddr, running, wrap, done, cfgErr
    );

    modport slave (
        input  tick, start, stop, loopMode, startAddr, endAddr, step, jump, jumpAddr,
        output memAddr, running, wrap, done, cfgErr
    );
endinterface

// File: rtl/loop_program_counter.sv
// loop_program_counter: windowed, strided memory address generator with loop/one-shot modes
module loop_program_counter #(
    parameter int DEPTH      = 20480,
    parameter int ADDR_WIDTH = 15,
    parameter int STEP_WIDTH = 4
) (
    input logic                 clk,
    input logic                 rstN,
    loop_program_counter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_start;
    logic [ADDR_WIDTH-1:0] r_end;
    logic [STEP_WIDTH-1:0] r_step;
    logic                  r_loop;
    logic                  r_wrap;
    logic                  r_cfg_err;

    logic                  w_stop;
    logic                  w_cfg_ok;
    logic                  w_jump_ok;
    logic [ADDR_WIDTH:0]   w_next;
    logic                  w_past_end;

    // Next address is one bit wider so a stride past the top of the address space is still seen as past the end
    always_comb begin
        w_stop     = bus.stop && r_state != IDLE;
        w_cfg_ok   = bus.startAddr <= bus.endAddr && {1'b0, bus.endAddr} <= LAST && |bus.step;
        w_jump_ok  = bus.jumpAddr >= r_start && bus.jumpAddr <= r_end;
        w_next     = {1'b0, r_addr} + {{(ADDR_WIDTH+1-STEP_WIDTH){1'b0}}, r_step};
        w_past_end = w_next > {1'b0, r_end};
    end

    // Control priority: stop, then start (restart allowed), then jump, then tick
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_start   <= '0;
            r_end     <= '0;
            r_step    <= '0;
            r_loop    <= 1'b0;
            r_wrap    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_wrap    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (w_stop) begin
                r_state <= IDLE;
            end else if (bus.start) begin
                if (w_cfg_ok) begin
                    r_start <= bus.startAddr;
                    r_end   <= bus.endAddr;
                    r_step  <= bus.step;
                    r_loop  <= bus.loopMode;
                    r_addr  <= bus.startAddr;
                    r_state <= RUN;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if (r_state == RUN) begin
                if (bus.jump) begin
                    if (w_jump_ok) r_addr <= bus.jumpAddr;
                end else if (bus.tick) begin
                    if (!w_past_end) begin
                        r_addr <= w_next[ADDR_WIDTH-1:0];
                    end else if (r_loop) begin
                        r_addr <= r_start;
                        r_wrap <= 1'b1;
                    end else begin
                        r_state <= DONE;
                    end
                end
            end
        end
    end

    assign bus.memAddr = r_addr;
    assign bus.running = r_state == RUN;
    assign bus.done    = r_state == DONE;
    assign bus.wrap    = r_wrap;
    assign bus.cfgErr  = r_cfg_err;
endmodule

// File: tb/tb_loop_program_counter.sv
// tb_loop_program_counter: scoreboard bench with directed and random stimulus against a reference model
module tb_loop_program_counter;
    localparam int DEPTH = 20480;
    localparam int AW    = 15;
    localparam int SW    = 4;

    typedef struct {
        int addr;
        bit run;
        bit done;
        bit wrap;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb[$];

    // Reference model: 0 idle, 1 running, 2 finished
    int m_mode, m_addr, m_lo, m_hi, m_stride;
    bit m_loop;

    loop_program_counter_if #(.ADDR_WIDTH(AW), .STEP_WIDTH(SW)) bus ();

    loop_program_counter #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .STEP_WIDTH(SW)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int got, int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endfunction

    // Monitor: the DUT presents a new status word after every clock edge
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb memAddr", int'(bus.memAddr), e.addr);
            chk("sb running", int'(bus.running), int'(e.run));
            chk("sb done", int'(bus.done), int'(e.done));
            chk("sb wrap", int'(bus.wrap), int'(e.wrap));
            chk("sb cfgErr", int'(bus.cfgErr), int'(e.err));
            if (bus.wrap && bus.cfgErr) chk("wrap/cfgErr exclusive", 1, 0);
            if (int'(bus.memAddr) >= DEPTH) chk("memAddr in range", int'(bus.memAddr), DEPTH - 1);
        end
    end

    function automatic void model_reset();
        m_mode = 0; m_addr = 0; m_lo = 0; m_hi = 0; m_stride = 0; m_loop = 0;
    endfunction

    // Predict the outputs after the coming edge from the documented control rules
    function automatic exp_t predict();
        exp_t e;
        int sa, ea, st, ja;
        sa = int'(bus.startAddr); ea = int'(bus.endAddr); st = int'(bus.step); ja = int'(bus.jumpAddr);
        e.wrap = 0; e.err = 0;
        if (bus.stop && m_mode != 0) m_mode = 0;
        else if (bus.start) begin
            if (sa > ea || ea > DEPTH - 1 || st == 0) e.err = 1;
            else begin
                m_lo = sa; m_hi = ea; m_stride = st; m_loop = bus.loopMode;
                m_addr = sa; m_mode = 1;
            end
        end else if (m_mode == 1 && bus.jump) begin
            if (ja >= m_lo && ja <= m_hi) m_addr = ja;
        end else if (m_mode == 1 && bus.tick) begin
            if (m_addr + m_stride <= m_hi) m_addr = m_addr + m_stride;
            else if (m_loop) begin m_addr = m_lo; e.wrap = 1; end
            else m_mode = 2;
        end
        e.addr = m_addr; e.run = m_mode == 1; e.done = m_mode == 2;
        return e;
    endfunction

    task automatic apply(input bit t, input bit s, input bit p, input bit j);
        bus.tick = t; bus.start = s; bus.stop = p; bus.jump = j;
        sb.push_back(predict());
        @(negedge clk);
        bus.tick = 0; bus.start = 0; bus.stop = 0; bus.jump = 0;
    endtask

    task automatic cfg(input int sa, input int ea, input int st, input bit lp);
        bus.startAddr = AW'(sa); bus.endAddr = AW'(ea); bus.step = SW'(st); bus.loopMode = lp;
    endtask

    int seq1[8] = '{1, 2, 3, 4, 5, 0, 1, 2};

    initial begin
        bus.tick = 0; bus.start = 0; bus.stop = 0; bus.jump = 0; bus.jumpAddr = '0;
        cfg(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset memAddr", int'(bus.memAddr), 0);
        chk("reset running", int'(bus.running), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset wrap", int'(bus.wrap), 0);
        chk("reset cfgErr", int'(bus.cfgErr), 0);
        rstN = 1'b1;
        @(negedge clk);

        // Loop window 0..5, step 1, tick also coincident with start is ignored
        cfg(0, 5, 1, 1);
        apply(1, 1, 0, 0);
        chk("t1 start addr", int'(bus.memAddr), 0);
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 0, 0);
            chk("t1 addr", int'(bus.memAddr), seq1[i]);
            chk("t1 wrap", int'(bus.wrap), int'(i == 5));
        end

        // One-shot 10..20 step 4
        cfg(10, 20, 4, 0);
        apply(0, 1, 0, 0);
        apply(1, 0, 0, 0); chk("t2 addr14", int'(bus.memAddr), 14);
        apply(1, 0, 0, 0); chk("t2 addr18", int'(bus.memAddr), 18);
        apply(1, 0, 0, 0);
        chk("t2 done", int'(bus.done), 1);
        chk("t2 running", int'(bus.running), 0);
        chk("t2 hold", int'(bus.memAddr), 18);
        apply(1, 0, 0, 0); chk("t2 hold2", int'(bus.memAddr), 18);

        // Config rejects from IDLE
        apply(0, 0, 1, 0); chk("t3 idle", int'(bus.done), 0);
        cfg(5, 3, 1, 0); apply(0, 1, 0, 0);
        chk("t3 err start>end", int'(bus.cfgErr), 1); chk("t3 addr", int'(bus.memAddr), 18);
        chk("t3 not running", int'(bus.running), 0);
        apply(0, 0, 0, 0); chk("t3 pulse", int'(bus.cfgErr), 0);
        cfg(0, 10, 0, 0); apply(0, 1, 0, 0); chk("t3 err step0", int'(bus.cfgErr), 1);
        cfg(0, DEPTH, 1, 0); apply(0, 1, 0, 0); chk("t3 err end=DEPTH", int'(bus.cfgErr), 1);

        // Jumps in window 0..100
        cfg(0, 100, 1, 1); apply(0, 1, 0, 0);
        repeat (3) apply(1, 0, 0, 0);
        bus.jumpAddr = AW'(50); apply(1, 0, 0, 1); chk("t4 jump50", int'(bus.memAddr), 50);
        bus.jumpAddr = AW'(200); apply(0, 0, 0, 1); chk("t4 jump200 ignored", int'(bus.memAddr), 50);
        apply(1, 0, 0, 0); chk("t4 continue", int'(bus.memAddr), 51);

        // Stop with coincident tick, then async reset while running
        apply(0, 1, 0, 0);
        repeat (7) apply(1, 0, 0, 0);
        apply(1, 0, 1, 0);
        chk("t5 stop addr", int'(bus.memAddr), 7); chk("t5 stop running", int'(bus.running), 0);
        apply(0, 1, 0, 0);
        repeat (3) apply(1, 0, 0, 0);
        #2 rstN = 1'b0;
        #1;
        chk("t5 async addr", int'(bus.memAddr), 0);
        chk("t5 async running", int'(bus.running), 0);
        model_reset();
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Top-of-memory window: every tick wraps
        cfg(DEPTH - 10, DEPTH - 1, 15, 1); apply(0, 1, 0, 0);
        chk("t6 start", int'(bus.memAddr), DEPTH - 10);
        for (int i = 0; i < 4; i++) begin
            apply(1, 0, 0, 0);
            chk("t6 addr", int'(bus.memAddr), DEPTH - 10);
            chk("t6 wrap", int'(bus.wrap), 1);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int sa, ea, r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin sa = DEPTH - int'($urandom_range(1, 30)); ea = DEPTH - 1; end
            else begin
                sa = int'($urandom_range(0, 60));
                ea = r == 1 ? DEPTH : (r == 2 && sa > 0) ? sa - 1 : sa + int'($urandom_range(0, 40));
            end
            cfg(sa, ea, int'($urandom_range(0, 15)), 1'($urandom));
            bus.jumpAddr = AW'($urandom_range(0, 110));
            apply(1'($urandom), $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 14) == 0);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
